// File: rtl/control_ajuste_hora_pkg.sv
// Shared definitions for the time-setting controller: FSM state encoding,
// field-select codes and the field rotation helpers.
// Optional feature: define CONTROL_TIMER_FIELDS_EN to extend the rotation
// with the timer fields (13..15).
package control_ajuste_hora_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EDIT = 2'd1,
      ST_SAVE = 2'd2
   } state_t;

   // Field-select codes seen by the 2-digit counters.
   typedef enum logic [3:0] {
      FIELD_NONE = 4'd0,
      FIELD_HH   = 4'd10,
      FIELD_MM   = 4'd11,
      FIELD_SS   = 4'd12,
      FIELD_T_HH = 4'd13,
      FIELD_T_MM = 4'd14,
      FIELD_T_SS = 4'd15
   } field_t;

`ifdef CONTROL_TIMER_FIELDS_EN
   localparam int FIELD_COUNT = 6;
`else
   localparam int FIELD_COUNT = 3;
`endif

   // Last code of the rotation; the rotation always starts at FIELD_HH.
   localparam field_t FIELD_LAST = field_t'(4'(FIELD_HH + FIELD_COUNT - 1));

   // Right rotation: HH -> ... -> LAST -> HH.
   function automatic field_t next_field(input field_t f);
      if (f >= FIELD_LAST || f < FIELD_HH) return FIELD_HH;
      return field_t'(f + 4'd1);
   endfunction

   // Left rotation: LAST -> ... -> HH -> LAST.
   function automatic field_t prev_field(input field_t f);
      if (f <= FIELD_HH || f > FIELD_LAST) return FIELD_LAST;
      return field_t'(f - 4'd1);
   endfunction

endpackage

// File: rtl/control_ajuste_hora_detector.sv
// Button front end: registers a debounced level, produces a one-cycle rising
// edge tick and, while the button is held alone, auto-repeat ticks after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module detector_flanco_repeticion #(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic inhibit,
   input  logic clr,
   output logic level,
   output logic edge_tick,
   output logic repeat_tick
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   logic          btn_q;
   logic          btn_prev;
   logic          repeating;
   logic [CW-1:0] cnt;
   logic          holding;

   assign level       = btn_q;
   assign edge_tick   = btn_q & ~btn_prev;
   assign holding     = btn_q & ~inhibit & ~clr;
   // cnt equals the number of cycles held so far, so the first repeat lands
   // exactly REPEAT_DELAY cycles after the edge tick.
   assign repeat_tick = holding & (cnt == (repeating ? PERIOD_C : DELAY_C));

   // Level/edge registers and the held-alone repeat counter.
   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q     <= 1'b0;
         btn_prev  <= 1'b0;
         repeating <= 1'b0;
         cnt       <= '0;
      end else begin
         btn_q    <= btn;
         btn_prev <= btn_q;
         if (!holding) begin
            cnt       <= '0;
            repeating <= 1'b0;
         end else if (repeat_tick) begin
            cnt       <= ONE_C;
            repeating <= 1'b1;
         end else begin
            cnt <= cnt + ONE_C;
         end
      end
   end

endmodule

// File: rtl/control_ajuste_hora.sv
// Time-setting controller: IDLE/EDIT/SAVE FSM that selects the field being
// edited, issues up/down pulses (with auto-repeat) and hands the result to
// the RTC interface with a bounded write handshake.
// Optional feature: CONTROL_TIMER_FIELDS_EN adds timer fields 13..15.
module control_ajuste_hora
   import control_ajuste_hora_pkg::*;
#(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int ACK_TIMEOUT   = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_prog,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       wr_ack,
   output logic [3:0] en_count,
   output logic       enUP,
   output logic       enDOWN,
   output logic       prog_mode,
   output logic       wr_req,
   output logic       timeout_err
);

   localparam int ACW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACW-1:0] ACK_LAST = ACW'(ACK_TIMEOUT - 1);
   localparam logic [ACW-1:0] ACK_ONE  = ACW'(1);

   state_t         state;
   field_t         field_q;
   logic [ACW-1:0] ack_cnt;

   logic prog_tick, left_tick, right_tick, up_tick, down_tick;
   logic up_rep, down_rep, up_level, down_level;
   logic in_edit, field_evt, rep_clr, up_fire, down_fire;
   logic unused_prog_level, unused_left_level, unused_right_level;
   logic unused_prog_rep, unused_left_rep, unused_right_rep;

   assign in_edit   = (state == ST_EDIT);
   assign field_evt = in_edit & (left_tick | right_tick);
   // Repeat timing restarts on any field change and whenever not editing.
   assign rep_clr   = ~in_edit | field_evt;
   // Either button level high on the other side blocks the pulse entirely.
   assign up_fire   = (up_tick | up_rep) & ~down_level;
   assign down_fire = (down_tick | down_rep) & ~up_level;
   assign en_count  = field_q;

   detector_flanco_repeticion #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_det_up (
      .clk(clk), .reset(reset), .btn(btn_up), .inhibit(down_level), .clr(rep_clr),
      .level(up_level), .edge_tick(up_tick), .repeat_tick(up_rep)
   );

   detector_flanco_repeticion #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_det_down (
      .clk(clk), .reset(reset), .btn(btn_down), .inhibit(up_level), .clr(rep_clr),
      .level(down_level), .edge_tick(down_tick), .repeat_tick(down_rep)
   );

   // Edge-only buttons: repeat permanently inhibited.
   detector_flanco_repeticion #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_det_prog (
      .clk(clk), .reset(reset), .btn(btn_prog), .inhibit(1'b1), .clr(1'b1),
      .level(unused_prog_level), .edge_tick(prog_tick), .repeat_tick(unused_prog_rep)
   );

   detector_flanco_repeticion #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_det_left (
      .clk(clk), .reset(reset), .btn(btn_left), .inhibit(1'b1), .clr(1'b1),
      .level(unused_left_level), .edge_tick(left_tick), .repeat_tick(unused_left_rep)
   );

   detector_flanco_repeticion #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_det_right (
      .clk(clk), .reset(reset), .btn(btn_right), .inhibit(1'b1), .clr(1'b1),
      .level(unused_right_level), .edge_tick(right_tick), .repeat_tick(unused_right_rep)
   );

   // Controller FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         field_q     <= FIELD_NONE;
         ack_cnt     <= '0;
         enUP        <= 1'b0;
         enDOWN      <= 1'b0;
         prog_mode   <= 1'b0;
         wr_req      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         enUP   <= 1'b0;
         enDOWN <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (prog_tick) begin
                  state       <= ST_EDIT;
                  field_q     <= FIELD_HH;
                  prog_mode   <= 1'b1;
                  timeout_err <= 1'b0;
               end
            end
            ST_EDIT: begin
               if (prog_tick) begin
                  state     <= ST_SAVE;
                  field_q   <= FIELD_NONE;
                  prog_mode <= 1'b0;
                  wr_req    <= 1'b1;
                  ack_cnt   <= '0;
               end else if (field_evt) begin
                  // Left and right together cancel; either one suppresses pulses.
                  if (right_tick && !left_tick) field_q <= next_field(field_q);
                  else if (left_tick && !right_tick) field_q <= prev_field(field_q);
               end else begin
                  enUP   <= up_fire;
                  enDOWN <= down_fire;
               end
            end
            ST_SAVE: begin
               if (wr_ack) begin
                  wr_req <= 1'b0;
                  state  <= ST_IDLE;
               end else if (ack_cnt == ACK_LAST) begin
                  wr_req      <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  ack_cnt <= ack_cnt + ACK_ONE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               field_q   <= FIELD_NONE;
               prog_mode <= 1'b0;
               wr_req    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_ajuste_hora.sv
// Self-checking bench for control_ajuste_hora: a behavioural model derived
// from the button/field/handshake rules is compared with the DUT on every
// falling edge, and directed scenarios pin the model with literal values.
module tb_control_ajuste_hora;

   localparam int RD = 20;
   localparam int RP = 5;
   localparam int AT = 16;
`ifdef CONTROL_TIMER_FIELDS_EN
   localparam int NF = 6;
`else
   localparam int NF = 3;
`endif
   localparam int B_PROG = 4, B_LEFT = 3, B_RIGHT = 2, B_UP = 1, B_DOWN = 0;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] btn = '0;
   logic       wr_ack = 1'b0;
   logic [3:0] en_count;
   logic       enUP, enDOWN, prog_mode, wr_req, timeout_err;

   int n_checks = 0;
   int n_pass = 0;
   int up_pulses = 0, dn_pulses = 0, req_cycles = 0;

   control_ajuste_hora #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .reset(reset),
      .btn_prog(btn[B_PROG]), .btn_left(btn[B_LEFT]), .btn_right(btn[B_RIGHT]),
      .btn_up(btn[B_UP]), .btn_down(btn[B_DOWN]), .wr_ack(wr_ack),
      .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
      .prog_mode(prog_mode), .wr_req(wr_req), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // ---------------- behavioural model ----------------
   int m_mode = 0;          // 0 idle, 1 edit, 2 save
   int m_fidx = 0;          // position in the field rotation (0 = hours)
   int m_save_cycles = 0;
   int up_run = 0, dn_run = 0;   // cycles a button has been held alone while editing
   bit m_up = 0, m_dn = 0, m_req = 0, m_err = 0;
   bit [4:0] lv = '0, lv_old = '0; // levels seen by the controller now / one cycle earlier

   function automatic int exp_field();
      return (m_mode == 1) ? 10 + m_fidx : 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_fidx = 0; m_save_cycles = 0; up_run = 0; dn_run = 0;
      m_up = 0; m_dn = 0; m_req = 0; m_err = 0; lv = '0; lv_old = '0;
   endtask

   task automatic model_edge();
      bit [4:0] t;
      bit edit, fchg, up_alone, dn_alone, up_rep, dn_rep;
      t        = lv & ~lv_old;
      edit     = (m_mode == 1);
      fchg     = edit && (t[B_LEFT] || t[B_RIGHT]);
      up_alone = edit && !fchg && lv[B_UP] && !lv[B_DOWN];
      dn_alone = edit && !fchg && lv[B_DOWN] && !lv[B_UP];
      up_rep   = up_alone && up_run >= RD && ((up_run - RD) % RP == 0);
      dn_rep   = dn_alone && dn_run >= RD && ((dn_run - RD) % RP == 0);
      m_up = 0;
      m_dn = 0;
      case (m_mode)
         0: if (t[B_PROG]) begin m_mode = 1; m_fidx = 0; m_err = 0; end
         1: begin
            if (t[B_PROG]) begin m_mode = 2; m_req = 1; m_save_cycles = 0; end
            else if (fchg) m_fidx = (m_fidx + NF + int'(t[B_RIGHT]) - int'(t[B_LEFT])) % NF;
            else begin
               m_up = (t[B_UP] || up_rep) && !lv[B_DOWN];
               m_dn = (t[B_DOWN] || dn_rep) && !lv[B_UP];
            end
         end
         default: begin
            m_save_cycles++;
            if (wr_ack) begin m_req = 0; m_mode = 0; end
            else if (m_save_cycles == AT) begin m_req = 0; m_err = 1; m_mode = 0; end
         end
      endcase
      up_run = up_alone ? up_run + 1 : 0;
      dn_run = dn_alone ? dn_run + 1 : 0;
      lv_old = lv;
      lv     = btn;
   endtask

   // Model advances on the same edges as the DUT.
   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else model_edge();
   end

   // Compare DUT against the model on every falling edge and tally pulses.
   always @(negedge clk) begin
      check("en_count", int'(en_count), exp_field());
      check("enUP", int'(enUP), int'(m_up));
      check("enDOWN", int'(enDOWN), int'(m_dn));
      check("prog_mode", int'(prog_mode), int'(m_mode == 1));
      check("wr_req", int'(wr_req), int'(m_req));
      check("timeout_err", int'(timeout_err), int'(m_err));
      if (enUP) up_pulses++;
      if (enDOWN) dn_pulses++;
      if (wr_req) req_cycles++;
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int b);
      btn[b] = 1'b1;
      step(1);
      btn[b] = 1'b0;
      step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base_u, base_d, base_r;
      step(3);
      check("rst_en_count", int'(en_count), 0);
      check("rst_prog_mode", int'(prog_mode), 0);
      check("rst_wr_req", int'(wr_req), 0);
      check("rst_timeout_err", int'(timeout_err), 0);
      reset = 1'b1;
      step(2);

      // Enter EDIT.
      press(B_PROG);
      check("edit_prog_mode", int'(prog_mode), 1);
      check("edit_field_hh", int'(en_count), 10);

      // Right rotation.
      press(B_RIGHT);
      check("right1", int'(en_count), 11);
      press(B_RIGHT);
      check("right2", int'(en_count), 12);
      press(B_RIGHT);
`ifdef CONTROL_TIMER_FIELDS_EN
      check("right3", int'(en_count), 13);
`else
      check("right3", int'(en_count), 10);
`endif
      // Left rotation back one step.
      press(B_LEFT);
      check("left1", int'(en_count), 12);
      press(B_RIGHT);

      // Single up and down ticks.
      base_u = up_pulses; base_d = dn_pulses;
      press(B_UP);
      step(2);
      check("single_up", up_pulses - base_u, 1);
      press(B_DOWN);
      step(2);
      check("single_down", dn_pulses - base_d, 1);

      // Held up: edge pulse plus two repeats.
      base_u = up_pulses; base_d = dn_pulses;
      btn[B_UP] = 1'b1;
      step(RD + 2 * RP);
      btn[B_UP] = 1'b0;
      step(4);
      check("hold_up_pulses", up_pulses - base_u, 3);
      check("hold_up_no_down", dn_pulses - base_d, 0);

      // Up and down together: nothing.
      base_u = up_pulses; base_d = dn_pulses;
      btn[B_UP] = 1'b1; btn[B_DOWN] = 1'b1;
      step(RD + 2 * RP);
      btn[B_UP] = 1'b0; btn[B_DOWN] = 1'b0;
      step(4);
      check("both_up", up_pulses - base_u, 0);
      check("both_down", dn_pulses - base_d, 0);

      // Up together with right: field moves, no pulse.
      base_u = up_pulses;
      btn[B_UP] = 1'b1; btn[B_RIGHT] = 1'b1;
      step(1);
      btn[B_UP] = 1'b0; btn[B_RIGHT] = 1'b0;
      step(3);
`ifdef CONTROL_TIMER_FIELDS_EN
      check("up_right_field", int'(en_count), 14);
`else
      check("up_right_field", int'(en_count), 11);
`endif
      check("up_right_no_pulse", up_pulses - base_u, 0);

      // SAVE with ack after seven request cycles.
      base_r = req_cycles;
      press(B_PROG);
      check("save_wr_req", int'(wr_req), 1);
      check("save_en_count", int'(en_count), 0);
      step(6);
      wr_ack = 1'b1;
      step(1);
      wr_ack = 1'b0;
      check("ack_wr_req_low", int'(wr_req), 0);
      check("ack_prog_mode", int'(prog_mode), 0);
      step(2);
      check("ack_req_cycles", req_cycles - base_r, 7);

      // Stray ack in IDLE and buttons in IDLE are ignored.
      wr_ack = 1'b1;
      press(B_UP);
      press(B_RIGHT);
      wr_ack = 1'b0;
      step(2);
      check("idle_wr_req", int'(wr_req), 0);
      check("idle_en_count", int'(en_count), 0);

      // Timeout path.
      press(B_PROG);
      base_r = req_cycles;
      press(B_PROG);
      for (int i = 0; i < 3 * AT && wr_req; i++) step(1);
      check("timeout_wr_req_dropped", int'(wr_req), 0);
      step(1);
      check("timeout_req_cycles", req_cycles - base_r, 16);
      check("timeout_err_set", int'(timeout_err), 1);
      press(B_PROG);
      check("timeout_err_cleared", int'(timeout_err), 0);
      check("reedit_field", int'(en_count), 10);

      // Reset in the middle of SAVE.
      press(B_PROG);
      check("save2_wr_req", int'(wr_req), 1);
      step(3);
      #2 reset = 1'b0;
      #1;
      check("async_rst_wr_req", int'(wr_req), 0);
      check("async_rst_en_count", int'(en_count), 0);
      @(negedge clk);
      reset = 1'b1;
      step(5);
      check("post_rst_wr_req", int'(wr_req), 0);
      check("post_rst_prog_mode", int'(prog_mode), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/control_ajuste_hora.md
CONTROL_AJUSTE_HORA -- requirements
Module: control_ajuste_hora

Interface
REQ-001 Parameter REPEAT_DELAY, default 50_000_000, is the number of clk cycles a held up/down button waits before auto-repeat starts.
REQ-002 Parameter REPEAT_PERIOD, default 10_000_000, is the number of clk cycles between auto-repeat pulses.
REQ-003 Parameter ACK_TIMEOUT, default 1024, is the maximum number of cycles spent in SAVE waiting for wr_ack.
REQ-004 Port clk: input, 1 bit. Single system clock; all logic is on its rising edge.
REQ-005 Port reset: input, 1 bit. Asynchronous, active-low reset.
REQ-006 Ports btn_prog, btn_left, btn_right, btn_up, btn_down: inputs, 1 bit each. Already-debounced button levels.
REQ-007 Port wr_ack: input, 1 bit. RTC interface acknowledge for a write request.
REQ-008 Port en_count: output, 4 bits. Field-select code to the 2-digit counters (0 = none).
REQ-009 Ports enUP, enDOWN: outputs, 1 bit each. One-cycle increment and decrement pulses to the selected counter.
REQ-010 Port prog_mode: output, 1 bit. High while the FSM is in EDIT.
REQ-011 Port wr_req: output, 1 bit. Write request to the RTC interface.
REQ-012 Port timeout_err: output, 1 bit. Sticky flag set on an ack timeout.

Function
REQ-013 Every button SHALL be registered and rising-edge detected; only edge ticks advance the FSM, except up/down auto-repeat.
REQ-014 The FSM SHALL have exactly three states: IDLE, EDIT and SAVE.
REQ-015 In IDLE, a btn_prog tick SHALL move the FSM to EDIT and set en_count to 10 (hours).
REQ-016 Field codes SHALL be 10 = hours, 11 = minutes, 12 = seconds.
REQ-017 In EDIT, a btn_right tick SHALL advance the field 10→11→12→10, and a btn_left tick SHALL step it 12→11→10→12.
REQ-018 In EDIT, a btn_up tick SHALL produce enUP high for exactly 1 cycle in the next cycle, and btn_down SHALL do the same on enDOWN.
REQ-019 If btn_up and btn_down are both high, or both tick together, no pulse SHALL be emitted.
REQ-020 Auto-repeat: when up or down is held alone for REPEAT_DELAY cycles, a further pulse SHALL be emitted, then one every REPEAT_PERIOD cycles until release; the repeat counter SHALL clear on release or on a field change.
REQ-021 enUP and enDOWN SHALL never be high simultaneously, and SHALL never be high outside EDIT.
REQ-022 A left/right tick in the same cycle as an up/down tick SHALL apply the field change first and suppress the pulse.
REQ-023 In EDIT, a btn_prog tick SHALL move the FSM to SAVE, set en_count to 0, and assert wr_req.
REQ-024 In SAVE, wr_req SHALL stay high until wr_ack is sampled high; the FSM SHALL then drop wr_req and return to IDLE on the following cycle.
REQ-025 If wr_ack has not arrived after ACK_TIMEOUT cycles in SAVE, the FSM SHALL drop wr_req, set timeout_err and return to IDLE.
REQ-026 timeout_err SHALL clear on the next entry into EDIT.
REQ-027 In SAVE and IDLE, all button ticks other than btn_prog in IDLE SHALL be ignored.
REQ-028 wr_ack arriving outside SAVE SHALL be ignored.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 Asserting reset (low) SHALL immediately force state IDLE, en_count=0, enUP=0, enDOWN=0, prog_mode=0, wr_req=0, timeout_err=0, clear the repeat and timeout counters, and clear the edge registers.
REQ-031 A reset during SAVE SHALL abandon the write; no wr_req SHALL follow reset release.

Configuration
REQ-032 With macro CONTROL_TIMER_FIELDS_EN defined, the field rotation SHALL extend to 10→11→12→13→14→15→10, where 13–15 are timer hours, minutes and seconds; left rotation SHALL be the reverse.
REQ-033 Without CONTROL_TIMER_FIELDS_EN, codes 13–15 SHALL never appear on en_count.

Structure
REQ-034 A shared package SHALL hold the state encoding, the field-code constants (FIELD_NONE=0, FIELD_HH=10 … FIELD_T_SS=15) and the field count.
REQ-035 One sub-module, detector_flanco_repeticion, SHALL provide edge detection plus the auto-repeat counter, instantiated for up and down; the left, right and prog buttons SHALL use its edge output only.

Verification
REQ-036 Reset release, then btn_prog pulse → prog_mode=1 and en_count=10 within 2 cycles.
REQ-037 In EDIT, btn_right ×3 → en_count goes 11, 12, 10 (with the macro: 11, 12, 13).
REQ-038 Hold btn_up for REPEAT_DELAY+2·REPEAT_PERIOD cycles (scaled 20/5) → exactly 3 enUP single-cycle pulses and enDOWN=0 throughout.
REQ-039 btn_up and btn_down high together → no pulses; btn_up with btn_right in the same cycle → field advances and no pulse.
REQ-040 btn_prog in EDIT with wr_ack returned 7 cycles later → wr_req high for 7 cycles, then IDLE with en_count=0.
REQ-041 No wr_ack (ACK_TIMEOUT=16) → wr_req drops after 16 cycles and timeout_err=1; asserting reset mid-SAVE clears wr_req asynchronously.
